// File: rtl/mult_div_sequencer_pkg.sv
// Shared types and encodings for the multiply/divide unit.
//   md_op_e      : MDControl encodings (11x reserved)
//   state_e      : sequencer states
//   md_result_t  : {hi, lo} result payload
package mult_div_sequencer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_result_t;

    // Ops that occupy the unit for a multi-cycle window
    function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
        return ~op[2];
    endfunction

    // Among mult/div ops, bit 1 selects the divide family
    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// EX-stage <-> mult/div unit bundle.
//   master (EX side) drives Start/MDControl/SrcA/SrcB, reads Busy/HI/LO.
//   slave  (unit)    drives Busy/HI/LO.
interface mult_div_sequencer_if;
    import mult_div_sequencer_pkg::*;

    logic                Start;
    logic [MD_OP_W-1:0]  MDControl;
    logic [XLEN-1:0]     SrcA;
    logic [XLEN-1:0]     SrcB;
    logic                Busy;
    logic [XLEN-1:0]     HI;
    logic [XLEN-1:0]     LO;

    modport master (
        output Start, MDControl, SrcA, SrcB,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDControl, SrcA, SrcB,
        output Busy, HI, LO
    );

endinterface

// File: rtl/mult_div_sequencer_md_result_calc.sv
// md_result_calc: combinational MIPS32 mult/div arithmetic.
//   src_a_i      : rs operand (dividend / multiplicand)
//   src_b_i      : rt operand (divisor / multiplier)
//   md_control_i : op encoding
//   res_o        : {hi, lo}; zero for non-arithmetic ops
module md_result_calc
    import mult_div_sequencer_pkg::*;
(
    input  logic [XLEN-1:0]    src_a_i,
    input  logic [XLEN-1:0]    src_b_i,
    input  logic [MD_OP_W-1:0] md_control_i,
    output md_result_t         res_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] abs_a, abs_b, q_mag, r_mag;

    // Operand magnitudes for the signed divide (INT_MIN maps to itself, read unsigned)
    assign abs_a = src_a_i[XLEN-1] ? (XLEN'(0) - src_a_i) : src_a_i;
    assign abs_b = src_b_i[XLEN-1] ? (XLEN'(0) - src_b_i) : src_b_i;

    always_comb begin
        res_o = '0;
        q_mag = '0;
        r_mag = '0;
        case (md_control_i)
            MD_MULT: begin
                res_o = {{XLEN{src_a_i[XLEN-1]}}, src_a_i} * {{XLEN{src_b_i[XLEN-1]}}, src_b_i};
            end
            MD_MULTU: begin
                res_o = {{XLEN{1'b0}}, src_a_i} * {{XLEN{1'b0}}, src_b_i};
            end
            MD_DIV: begin
                if (src_b_i == '0) begin
                    res_o.hi = src_a_i;
                    res_o.lo = '1;
                end else if (src_a_i == INT_MIN && src_b_i == '1) begin
                    res_o.hi = '0;
                    res_o.lo = INT_MIN;
                end else begin
                    // Truncate toward zero; remainder follows the dividend's sign
                    q_mag    = abs_a / abs_b;
                    r_mag    = abs_a % abs_b;
                    res_o.lo = (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]) ? (XLEN'(0) - q_mag) : q_mag;
                    res_o.hi = src_a_i[XLEN-1] ? (XLEN'(0) - r_mag) : r_mag;
                end
            end
            MD_DIVU: begin
                if (src_b_i == '0) begin
                    res_o.hi = src_a_i;
                    res_o.lo = '1;
                end else begin
                    res_o.lo = src_a_i / src_b_i;
                    res_o.hi = src_a_i % src_b_i;
                end
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: EX-stage multiply/divide unit owning HI/LO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   md (slave) : Start/MDControl/SrcA/SrcB in; Busy/HI/LO out (all registered)
// The result is computed on the Start cycle, held, and committed to HI/LO
// together once the fixed latency has elapsed.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    mult_div_sequencer_if.slave    md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic [XLEN-1:0]  hi_q,    hi_d;
    logic [XLEN-1:0]  lo_q,    lo_d;
    md_result_t       res_q,   res_d;
    md_result_t       calc_res;

    md_result_calc u_calc (
        .src_a_i      (md.SrcA),
        .src_b_i      (md.SrcB),
        .md_control_i (md.MDControl),
        .res_o        (calc_res)
    );

    // State, counter, holding and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    // Next-state: Start is only honoured in IDLE, so a Start while busy is dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (md.Start) begin
                    if (is_muldiv(md.MDControl)) begin
                        res_d   = calc_res;
                        cnt_d   = is_div(md.MDControl) ? DIV_LOAD : MULT_LOAD;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (md.MDControl == MD_MTHI) begin
                        hi_d = md.SrcA;
                    end else if (md.MDControl == MD_MTLO) begin
                        lo_d = md.SrcA;
                    end
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    hi_d    = res_q.hi;
                    lo_d    = res_q.lo;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign md.Busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule
